// File: rtl/ldpc_iter_ctrl.sv
// ---------------------------------------------------------------------------
// ldpc_iter_ctrl
//
// Iteration sequencer for the LDPC decoder. Once a codeword is in the LLR
// RAM it launches the original-LLR read pass, then alternates check-node
// and variable-node passes until the syndrome is clean (early termination
// build) or the per-frame iteration cap is reached. Every wait on an engine
// is guarded by a watchdog that aborts the frame with timeout_err.
//
// Build option:
//   LDPC_EARLY_TERM_EN  defined   -> stop as soon as syndrome_ok arrives
//                                    with vn_done.
//                       undefined -> always run the full latched cap;
//                                    dec_success reports the syndrome of
//                                    the final iteration.
//
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   frame_start           new codeword loaded (accepted only when idle)
//   max_iter_cfg          runtime iteration cap, sampled on frame accept
//   flag_org_read_start   1-cycle pulse: start original-LLR read pass
//   flag_org_read_end     end pulse from the org-read engine
//   cn_start / cn_done    check-node pass start / done pulses
//   vn_start / vn_done    variable-node pass start / done pulses
//   syndrome_ok           parity checks clean; valid with vn_done only
//   busy                  high whenever not idle
//   iter_cnt              completed iterations in the current frame
//   dec_done              1-cycle end-of-frame pulse
//   dec_success           frame result, held until next accepted frame
//   timeout_err           watchdog abort, held until next accepted frame
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ldpc_iter_ctrl #(
  parameter int MAX_ITER = 10,
  parameter int ITER_W   = 5,
  parameter int TIMEOUT  = 1023,
  parameter int TO_W     = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              frame_start,
  input  logic [ITER_W-1:0] max_iter_cfg,
  output logic              flag_org_read_start,
  input  logic              flag_org_read_end,
  output logic              cn_start,
  input  logic              cn_done,
  output logic              vn_start,
  input  logic              vn_done,
  input  logic              syndrome_ok,
  output logic              busy,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              dec_done,
  output logic              dec_success,
  output logic              timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ORG_START,
    S_ORG_WAIT,
    S_CN_START,
    S_CN_WAIT,
    S_VN_START,
    S_VN_WAIT,
    S_CHECK,
    S_FINISH
  } state_t;

  localparam logic [ITER_W-1:0] CAP_MAX = ITER_W'(MAX_ITER);
  // The watchdog value seen in the last permitted wait cycle. A wait state
  // therefore lasts at most TIMEOUT cycles before the abort edge.
  localparam logic [TO_W-1:0]   WD_LAST = TO_W'(TIMEOUT - 1);

  // Runtime cap saturation: 0 and anything above MAX_ITER mean MAX_ITER.
  function automatic logic [ITER_W-1:0] sat_cap(input logic [ITER_W-1:0] cfg);
    if ((cfg == '0) || (cfg > CAP_MAX)) begin
      return CAP_MAX;
    end
    return cfg;
  endfunction

  function automatic logic wd_expired(input logic [TO_W-1:0] wd);
    return (wd == WD_LAST);
  endfunction

  state_t            state_q, state_d;
  logic [ITER_W-1:0] iter_q,  iter_d;
  logic [ITER_W-1:0] cap_q,   cap_d;
  logic [TO_W-1:0]   wd_q,    wd_d;
  logic              synd_q,  synd_d;
  logic              succ_q,  succ_d;
  logic              terr_q,  terr_d;

  // State and flag registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      cap_q   <= CAP_MAX;
      wd_q    <= '0;
      synd_q  <= 1'b0;
      succ_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      cap_q   <= cap_d;
      wd_q    <= wd_d;
      synd_q  <= synd_d;
      succ_q  <= succ_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state logic. The watchdog defaults to zero, so it is automatically
  // cleared on entry to every wait state and only counts while waiting.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    cap_d   = cap_q;
    wd_d    = '0;
    synd_d  = synd_q;
    succ_d  = succ_q;
    terr_d  = terr_q;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_ORG_START;
          cap_d   = sat_cap(max_iter_cfg);
          iter_d  = '0;
          synd_d  = 1'b0;
          succ_d  = 1'b0;
          terr_d  = 1'b0;
        end
      end

      S_ORG_START: state_d = S_ORG_WAIT;

      S_ORG_WAIT: begin
        // A completion pulse in the expiry cycle takes priority.
        if (flag_org_read_end) begin
          state_d = S_CN_START;
        end else if (wd_expired(wd_q)) begin
          state_d = S_FINISH;
          succ_d  = 1'b0;
          terr_d  = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_CN_START: state_d = S_CN_WAIT;

      S_CN_WAIT: begin
        if (cn_done) begin
          state_d = S_VN_START;
        end else if (wd_expired(wd_q)) begin
          state_d = S_FINISH;
          succ_d  = 1'b0;
          terr_d  = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_VN_START: state_d = S_VN_WAIT;

      S_VN_WAIT: begin
        if (vn_done) begin
          state_d = S_CHECK;
          iter_d  = iter_q + 1'b1;
          synd_d  = syndrome_ok;
        end else if (wd_expired(wd_q)) begin
          state_d = S_FINISH;
          succ_d  = 1'b0;
          terr_d  = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_CHECK: begin
`ifdef LDPC_EARLY_TERM_EN
        if (synd_q) begin
          state_d = S_FINISH;
          succ_d  = 1'b1;
        end else if (iter_q == cap_q) begin
          state_d = S_FINISH;
          succ_d  = 1'b0;
        end else begin
          state_d = S_CN_START;
        end
`else
        // Full-cap mode: the syndrome only decides the reported result.
        if (iter_q == cap_q) begin
          state_d = S_FINISH;
          succ_d  = synd_q;
        end else begin
          state_d = S_CN_START;
        end
`endif
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state and flags.
  assign flag_org_read_start = (state_q == S_ORG_START);
  assign cn_start            = (state_q == S_CN_START);
  assign vn_start            = (state_q == S_VN_START);
  assign dec_done            = (state_q == S_FINISH);
  assign busy                = (state_q != S_IDLE);
  assign iter_cnt            = iter_q;
  assign dec_success         = succ_q;
  assign timeout_err         = terr_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
`timescale 1ns/1ps

module tb_ldpc_iter_ctrl;

  localparam int ITER_W  = 5;
  localparam int TIMEOUT = 1023;

  logic              sys_clk;
  logic              sys_rst;
  logic              frame_start;
  logic [ITER_W-1:0] max_iter_cfg;
  logic              flag_org_read_start;
  logic              flag_org_read_end;
  logic              cn_start;
  logic              cn_done;
  logic              vn_start;
  logic              vn_done;
  logic              syndrome_ok;
  logic              busy;
  logic [ITER_W-1:0] iter_cnt;
  logic              dec_done;
  logic              dec_success;
  logic              timeout_err;

  int checks   = 0;
  int failures = 0;

  // Pulse monitor: counts start/done pulses and flags out-of-order starts.
  int n_org     = 0;
  int n_cn      = 0;
  int n_vn      = 0;
  int n_done    = 0;
  int order_err = 0;
  int last_q    = 0;

  ldpc_iter_ctrl #(
    .MAX_ITER (10),
    .ITER_W   (ITER_W),
    .TIMEOUT  (TIMEOUT),
    .TO_W     (10)
  ) dut (
    .sys_clk             (sys_clk),
    .sys_rst             (sys_rst),
    .frame_start         (frame_start),
    .max_iter_cfg        (max_iter_cfg),
    .flag_org_read_start (flag_org_read_start),
    .flag_org_read_end   (flag_org_read_end),
    .cn_start            (cn_start),
    .cn_done             (cn_done),
    .vn_start            (vn_start),
    .vn_done             (vn_done),
    .syndrome_ok         (syndrome_ok),
    .busy                (busy),
    .iter_cnt            (iter_cnt),
    .dec_done            (dec_done),
    .dec_success         (dec_success),
    .timeout_err         (timeout_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (flag_org_read_start) begin
      n_org  <= n_org + 1;
      last_q <= 0;
    end
    if (cn_start) begin
      n_cn <= n_cn + 1;
      if (last_q == 1) order_err <= order_err + 1;
      last_q <= 1;
    end
    if (vn_start) begin
      n_vn <= n_vn + 1;
      if (last_q != 1) order_err <= order_err + 1;
      last_q <= 2;
    end
    if (dec_done) n_done <= n_done + 1;
  end

  // One cycle forward; sample and drive just after the falling edge.
  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Service one engine pass: the start pulse must be present in the current
  // cycle, the done pulse is returned lat cycles later. With inj set, a
  // stray frame_start and vn_done are injected 5 cycles into the wait.
  task automatic pass(input int which, input int lat, input bit synd, input bit inj);
    string tg;
    logic  s;
    if (which == 0) begin tg = "org_start"; s = flag_org_read_start; end
    else if (which == 1) begin tg = "cn_start"; s = cn_start; end
    else begin tg = "vn_start"; s = vn_start; end
    chk(tg, {31'd0, s}, 32'd1);
    for (int k = 1; k <= lat; k++) begin
      step();
      frame_start = 1'b0;
      vn_done     = 1'b0;
      if (inj && k == 5) begin
        frame_start = 1'b1;
        vn_done     = 1'b1;
      end
      if (k == lat) begin
        if (which == 0) flag_org_read_end = 1'b1;
        else if (which == 1) cn_done = 1'b1;
        else begin
          vn_done     = 1'b1;
          syndrome_ok = synd;
        end
      end
    end
    step();
    flag_org_read_end = 1'b0;
    cn_done           = 1'b0;
    vn_done           = 1'b0;
    syndrome_ok       = 1'b0;
    frame_start       = 1'b0;
  endtask

  // Run a whole frame expecting n_iter iterations and the given result.
  task automatic run_frame(input int cfg, input int n_iter, input int synd_at,
                           input int org_lat, input int lat, input int inj_iter,
                           input int new_cfg, input bit exp_succ);
    int org0, cn0, vn0, done0, ord0;
    org0 = n_org; cn0 = n_cn; vn0 = n_vn; done0 = n_done; ord0 = order_err;
    max_iter_cfg = ITER_W'(cfg);
    frame_start  = 1'b1;
    step();
    frame_start  = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    chk("iter_clr", {27'd0, iter_cnt}, 32'd0);
    chk("succ_clr", {31'd0, dec_success}, 32'd0);
    chk("terr_clr", {31'd0, timeout_err}, 32'd0);
    if (new_cfg >= 0) max_iter_cfg = ITER_W'(new_cfg);
    pass(0, org_lat, 1'b0, 1'b0);
    for (int i = 1; i <= n_iter; i++) begin
      if (i > 1) step();
      pass(1, lat, 1'b0, (i == inj_iter));
      pass(2, lat, (i == synd_at), 1'b0);
      chk("iter_at_check", {27'd0, iter_cnt}, i);
      chk("done_at_check", {31'd0, dec_done}, 32'd0);
    end
    step();
    chk("dec_done", {31'd0, dec_done}, 32'd1);
    chk("iter_final", {27'd0, iter_cnt}, n_iter);
    chk("dec_success", {31'd0, dec_success}, {31'd0, exp_succ});
    chk("terr_final", {31'd0, timeout_err}, 32'd0);
    step();
    chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("done_pulse", {31'd0, dec_done}, 32'd0);
    chk("succ_hold", {31'd0, dec_success}, {31'd0, exp_succ});
    chk("n_org", n_org - org0, 32'd1);
    chk("n_cn", n_cn - cn0, n_iter);
    chk("n_vn", n_vn - vn0, n_iter);
    chk("n_done", n_done - done0, 32'd1);
    chk("order", order_err - ord0, 32'd0);
  endtask

  initial begin
    int done0;
    sys_rst           = 1'b1;
    frame_start       = 1'b0;
    max_iter_cfg      = '0;
    flag_org_read_end = 1'b0;
    cn_done           = 1'b0;
    vn_done           = 1'b0;
    syndrome_ok       = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_iter", {27'd0, iter_cnt}, 32'd0);
    chk("rst_done", {31'd0, dec_done}, 32'd0);
    chk("rst_succ", {31'd0, dec_success}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    chk("rst_pulses", {29'd0, flag_org_read_start, cn_start, vn_start}, 32'd0);
    sys_rst = 1'b0;
    step();

    // Syndrome clean on the 3rd vn_done, cap 5
`ifdef LDPC_EARLY_TERM_EN
    run_frame(5, 3, 3, 128, 20, 0, -1, 1'b1);
`else
    run_frame(5, 5, 3, 128, 20, 0, -1, 1'b0);
`endif

    // cfg 0 selects MAX_ITER, never converges
    run_frame(0, 10, 0, 128, 20, 0, -1, 1'b0);

    // cfg above MAX_ITER also selects MAX_ITER
    run_frame(31, 10, 0, 3, 3, 0, -1, 1'b0);

    // Mid-frame frame_start and stray vn_done during CN_WAIT are ignored
    run_frame(2, 2, 2, 10, 20, 1, -1, 1'b1);

    // Cap latched at frame start; later cfg change has no effect
    run_frame(2, 2, 0, 10, 10, 0, 7, 1'b0);

    // Watchdog abort while withholding cn_done
    done0        = n_done;
    max_iter_cfg = ITER_W'(1);
    frame_start  = 1'b1;
    step();
    frame_start  = 1'b0;
    pass(0, 10, 1'b0, 1'b0);
    chk("to_cn_start", {31'd0, cn_start}, 32'd1);
    for (int k = 1; k <= TIMEOUT; k++) step();
    chk("to_not_yet", {31'd0, dec_done}, 32'd0);
    chk("to_still_busy", {31'd0, busy}, 32'd1);
    step();
    chk("to_dec_done", {31'd0, dec_done}, 32'd1);
    chk("to_terr", {31'd0, timeout_err}, 32'd1);
    chk("to_succ", {31'd0, dec_success}, 32'd0);
    step();
    chk("to_idle", {31'd0, busy}, 32'd0);
    chk("to_terr_hold", {31'd0, timeout_err}, 32'd1);
    chk("to_n_done", n_done - done0, 32'd1);

    // cn_done exactly on the expiry cycle wins; new frame clears timeout_err
    max_iter_cfg = ITER_W'(1);
    frame_start  = 1'b1;
    step();
    frame_start  = 1'b0;
    chk("race_terr_clr", {31'd0, timeout_err}, 32'd0);
    pass(0, 10, 1'b0, 1'b0);
    for (int k = 1; k <= TIMEOUT; k++) step();
    cn_done = 1'b1;
    step();
    cn_done = 1'b0;
    chk("race_no_terr", {31'd0, timeout_err}, 32'd0);
    chk("race_no_done", {31'd0, dec_done}, 32'd0);
    pass(2, 5, 1'b1, 1'b0);
    step();
    chk("race_dec_done", {31'd0, dec_done}, 32'd1);
    chk("race_succ", {31'd0, dec_success}, 32'd1);
    chk("race_iter", {27'd0, iter_cnt}, 32'd1);
    chk("race_terr_end", {31'd0, timeout_err}, 32'd0);
    step();

    // Reset during VN_WAIT of the 2nd iteration aborts silently
    max_iter_cfg = ITER_W'(5);
    frame_start  = 1'b1;
    step();
    frame_start  = 1'b0;
    pass(0, 10, 1'b0, 1'b0);
    pass(1, 20, 1'b0, 1'b0);
    pass(2, 20, 1'b0, 1'b0);
    step();
    pass(1, 20, 1'b0, 1'b0);
    chk("mid_iter", {27'd0, iter_cnt}, 32'd1);
    for (int k = 0; k < 5; k++) step();
    done0   = n_done;
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_iter", {27'd0, iter_cnt}, 32'd0);
    chk("mrst_done", {31'd0, dec_done}, 32'd0);
    for (int k = 0; k < 30; k++) step();
    chk("mrst_no_done", n_done - done0, 32'd0);
    chk("mrst_idle", {31'd0, busy}, 32'd0);
    run_frame(1, 1, 1, 10, 10, 0, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
